// File: rtl/cam_pkg.sv
// Shared types and constants for the parametrised CAM.
package cam_pkg;

  // Control FSM states: IDLE accepts commands, FLUSH walks and clears valid bits.
  typedef enum logic [0:0] {
    IDLE,
    FLUSH
  } cam_state_e;

  localparam int unsigned CamDefaultDataWidth = 32;
  localparam int unsigned CamDefaultAddrWidth = 5;

  // Number of entries addressed by an index of the given width.
  function automatic int unsigned cam_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Index width needed to address a given number of entries (at least 1 bit).
  function automatic int unsigned cam_index_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder for the CAM match vector.
// Purely combinational; index is 0 when nothing matches.
module cam_prio_enc #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic [DEPTH-1:0] match_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] index_o
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    hit_o   = |match_i;
    index_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_i[i]) begin
        index_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/param_cam.sv
// Parametrised CAM: indexed read/write/invalidate, multi-cycle flush and a
// two-stage pipelined associative search returning the lowest matching index.
// Optional feature macro: CAM_MATCH_COUNT_EN adds search_count_o (match popcount).
module param_cam
  import cam_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CamDefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = CamDefaultAddrWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  read_enable_i,
  input  logic [ADDR_WIDTH-1:0] read_index_i,
  input  logic                  write_enable_i,
  input  logic [ADDR_WIDTH-1:0] write_index_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  inval_enable_i,
  input  logic [ADDR_WIDTH-1:0] inval_index_i,
  input  logic                  flush_i,
  input  logic                  search_enable_i,
  input  logic [DATA_WIDTH-1:0] search_data_i,
  output logic                  ready_o,
  output logic                  read_valid_o,
  output logic [DATA_WIDTH-1:0] read_value_o,
  output logic                  search_valid_o,
  output logic                  search_hit_o,
  output logic [ADDR_WIDTH-1:0] search_index_o
`ifdef CAM_MATCH_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   search_count_o
`endif
);

  localparam int unsigned DEPTH = cam_depth(ADDR_WIDTH);

  cam_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                  ready;
  logic                  accept;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;

  logic                  read_valid_q;
  logic [DATA_WIDTH-1:0] read_value_q;

  logic [DEPTH-1:0]      match_d, match_q;
  logic                  s1_valid_q;
  logic                  enc_hit;
  logic [ADDR_WIDTH-1:0] enc_index;
  logic                  search_valid_q;
  logic                  search_hit_q;
  logic [ADDR_WIDTH-1:0] search_index_q;

  // A flush request in IDLE swallows every other command of that cycle.
  assign accept = ready & ~flush_i;

  // Control FSM next state, flush counter and ready.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    ready       = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (flush_i) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + ADDR_WIDTH'(1);
        if (flush_cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Valid bit next state: flush clears one entry per cycle; write beats invalidate.
  always_comb begin
    valid_d = valid_q;
    if (state_q == FLUSH) begin
      valid_d[flush_cnt_q] = 1'b0;
    end else if (accept) begin
      if (inval_enable_i) valid_d[inval_index_i] = 1'b0;
      if (write_enable_i) valid_d[write_index_i] = 1'b1;
    end
  end

  // Valid bits are the only part of the array that is reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Data array write port.
  always_ff @(posedge clk_i) begin
    if (accept && write_enable_i) begin
      data_q[write_index_i] <= write_data_i;
    end
  end

  // Indexed read: valid is a one-cycle strobe, value holds until the next read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      read_valid_q <= 1'b0;
      read_value_q <= '0;
    end else begin
      read_valid_q <= accept & read_enable_i & valid_q[read_index_i];
      if (accept && read_enable_i) begin
        read_value_q <= data_q[read_index_i];
      end
    end
  end

  // Stage 1 compare against pre-update contents.
  always_comb begin
    match_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_d[i] = valid_q[i] && (data_q[i] == search_data_i);
    end
  end

  // Stage 1 register: match snapshot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      match_q    <= '0;
    end else begin
      s1_valid_q <= accept & search_enable_i;
      match_q    <= match_d;
    end
  end

  cam_prio_enc #(
    .DEPTH (DEPTH),
    .IDX_W (ADDR_WIDTH)
  ) u_prio_enc (
    .match_i (match_q),
    .hit_o   (enc_hit),
    .index_o (enc_index)
  );

  // Stage 2 register: encoded result, zeroed when no search is in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      search_valid_q <= 1'b0;
      search_hit_q   <= 1'b0;
      search_index_q <= '0;
    end else begin
      search_valid_q <= s1_valid_q;
      search_hit_q   <= s1_valid_q & enc_hit;
      search_index_q <= s1_valid_q ? enc_index : '0;
    end
  end

`ifdef CAM_MATCH_COUNT_EN
  logic [ADDR_WIDTH:0] match_cnt;
  logic [ADDR_WIDTH:0] search_count_q;

  // Popcount of the stage-1 match vector.
  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_cnt = match_cnt + {{ADDR_WIDTH{1'b0}}, match_q[i]};
    end
  end

  // Count register aligned with the stage-2 result.
  always_ff @(posedge clk_i) begin
    if (rst_i) search_count_q <= '0;
    else       search_count_q <= s1_valid_q ? match_cnt : '0;
  end

  assign search_count_o = search_count_q;
`endif

  assign ready_o        = ready;
  assign read_valid_o   = read_valid_q;
  assign read_value_o   = read_value_q;
  assign search_valid_o = search_valid_q;
  assign search_hit_o   = search_hit_q;
  assign search_index_o = search_index_q;

endmodule

// File: tb/tb_param_cam.sv
// Self-checking bench for param_cam: reference model plus search scoreboard.
module tb_param_cam;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic          hit;
    logic [AW-1:0] idx;
    logic [AW:0]   cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          read_enable_i;
  logic [AW-1:0] read_index_i;
  logic          write_enable_i;
  logic [AW-1:0] write_index_i;
  logic [DW-1:0] write_data_i;
  logic          inval_enable_i;
  logic [AW-1:0] inval_index_i;
  logic          flush_i;
  logic          search_enable_i;
  logic [DW-1:0] search_data_i;
  logic          ready_o;
  logic          read_valid_o;
  logic [DW-1:0] read_value_o;
  logic          search_valid_o;
  logic          search_hit_o;
  logic [AW-1:0] search_index_o;
`ifdef CAM_MATCH_COUNT_EN
  logic [AW:0]   search_count_o;
`endif

  int errors = 0;
  int checks = 0;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [DW-1:0] m_data  [DEPTH];
  logic          m_valid [DEPTH];

  param_cam #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .read_enable_i   (read_enable_i),
    .read_index_i    (read_index_i),
    .write_enable_i  (write_enable_i),
    .write_index_i   (write_index_i),
    .write_data_i    (write_data_i),
    .inval_enable_i  (inval_enable_i),
    .inval_index_i   (inval_index_i),
    .flush_i         (flush_i),
    .search_enable_i (search_enable_i),
    .search_data_i   (search_data_i),
    .ready_o         (ready_o),
    .read_valid_o    (read_valid_o),
    .read_value_o    (read_value_o),
    .search_valid_o  (search_valid_o),
    .search_hit_o    (search_hit_o),
    .search_index_o  (search_index_o)
`ifdef CAM_MATCH_COUNT_EN
    ,
    .search_count_o  (search_count_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference search against the model contents at issue time.
  function automatic exp_t model_search(input logic [DW-1:0] key);
    exp_t e;
    e = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_valid[i] && m_data[i] == key) begin
        e.hit = 1'b1;
        e.idx = AW'(i);
        e.cnt = e.cnt + 1'b1;
      end
    end
    return e;
  endfunction

  // Scoreboard monitor: every search strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (search_valid_o === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_search_strobe: got hit=%0d index=%0d, expected no strobe",
                 search_hit_o, search_index_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (search_hit_o !== mon_e.hit || search_index_o !== mon_e.idx
`ifdef CAM_MATCH_COUNT_EN
            || search_count_o !== mon_e.cnt
`endif
           ) begin
          errors++;
`ifdef CAM_MATCH_COUNT_EN
          $display("FAIL search_result: got hit=%0d index=%0d count=%0d, expected hit=%0d index=%0d count=%0d",
                   search_hit_o, search_index_o, search_count_o, mon_e.hit, mon_e.idx, mon_e.cnt);
`else
          $display("FAIL search_result: got hit=%0d index=%0d, expected hit=%0d index=%0d",
                   search_hit_o, search_index_o, mon_e.hit, mon_e.idx);
`endif
        end
      end
    end
  end

  task automatic clear_inputs();
    read_enable_i   = 1'b0;
    read_index_i    = '0;
    write_enable_i  = 1'b0;
    write_index_i   = '0;
    write_data_i    = '0;
    inval_enable_i  = 1'b0;
    inval_index_i   = '0;
    flush_i         = 1'b0;
    search_enable_i = 1'b0;
    search_data_i   = '0;
  endtask

  task automatic set_write(input logic [AW-1:0] idx, input logic [DW-1:0] data);
    write_enable_i = 1'b1;
    write_index_i  = idx;
    write_data_i   = data;
  endtask

  task automatic set_inval(input logic [AW-1:0] idx);
    inval_enable_i = 1'b1;
    inval_index_i  = idx;
  endtask

  task automatic set_search(input logic [DW-1:0] key);
    search_enable_i = 1'b1;
    search_data_i   = key;
  endtask

  task automatic set_read(input logic [AW-1:0] idx);
    read_enable_i = 1'b1;
    read_index_i  = idx;
  endtask

  // Apply the staged commands for one cycle (IDLE only), updating the model.
  task automatic cycle();
    logic          re;
    logic          exp_rv;
    logic [DW-1:0] exp_rval;
    re       = read_enable_i;
    exp_rv   = 1'b0;
    exp_rval = '0;
    if (search_enable_i) sb_q.push_back(model_search(search_data_i));
    if (re) begin
      exp_rv   = m_valid[read_index_i];
      exp_rval = m_data[read_index_i];
    end
    if (inval_enable_i) m_valid[inval_index_i] = 1'b0;
    if (write_enable_i) begin
      m_data[write_index_i]  = write_data_i;
      m_valid[write_index_i] = 1'b1;
    end
    @(posedge clk);
    #1;
    clear_inputs();
    if (re) begin
      checks++;
      if (read_valid_o !== exp_rv || read_value_o !== exp_rval) begin
        errors++;
        $display("FAIL read: got valid=%0d value=%h, expected valid=%0d value=%h",
                 read_valid_o, read_value_o, exp_rv, exp_rval);
      end
    end
  endtask

  task automatic check_drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d outstanding searches, expected 0", name, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic model_clear_valid();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (ready_o !== 1'b1 || read_valid_o !== 1'b0 || read_value_o !== '0 ||
        search_valid_o !== 1'b0 || search_hit_o !== 1'b0 || search_index_o !== '0
`ifdef CAM_MATCH_COUNT_EN
        || search_count_o !== '0
`endif
       ) begin
      errors++;
      $display("FAIL %s: got ready=%0d rv=%0d rval=%h sv=%0d hit=%0d idx=%0d, expected 1 and zeros",
               name, ready_o, read_valid_o, read_value_o, search_valid_o, search_hit_o,
               search_index_o);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_clear_valid();
    sb_q.delete();
    check_idle_outputs("reset_outputs");
    // Read of an unwritten entry must not strobe valid.
    set_read(AW'(0));
    @(posedge clk);
    #1;
    clear_inputs();
    checks++;
    if (read_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_read_valid: got %0d, expected 0", read_valid_o);
    end
  endtask

  task automatic test_basic_search();
    set_write(AW'(3), 32'hDEADBEEF);
    cycle();
    set_search(32'hDEADBEEF);
    cycle();
    // Result must appear exactly two cycles after issue.
    checks++;
    if (search_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: got search_valid=%0d one cycle after issue, expected 0",
               search_valid_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (search_valid_o !== 1'b1 || search_hit_o !== 1'b1 || search_index_o !== AW'(3)) begin
      errors++;
      $display("FAIL basic_latency: got valid=%0d hit=%0d index=%0d, expected 1 1 3",
               search_valid_o, search_hit_o, search_index_o);
    end
    check_drain("basic");
  endtask

  task automatic test_lowest_index();
    set_write(AW'(7), 32'h55);
    cycle();
    set_write(AW'(2), 32'h55);
    cycle();
    set_search(32'h55);
    cycle();
    set_inval(AW'(2));
    cycle();
    set_search(32'h55);
    cycle();
    check_drain("lowest");
  endtask

  task automatic test_write_search_same();
    set_write(AW'(4), 32'hA5);
    set_search(32'hA5);
    cycle();
    set_search(32'hA5);
    cycle();
    check_drain("wr_search_same");
  endtask

  task automatic test_write_inval_same();
    set_write(AW'(9), 32'h12345678);
    set_inval(AW'(9));
    cycle();
    set_read(AW'(9));
    cycle();
    set_read(AW'(2));
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] keys [6];
    keys[0] = 32'hDEADBEEF;
    keys[1] = 32'h55;
    keys[2] = 32'hA5;
    keys[3] = 32'h0;
    keys[4] = 32'h12345678;
    keys[5] = 32'h55;
    for (int i = 0; i < 6; i++) begin
      set_search(keys[i]);
      set_read(AW'(i + 2));
      if (i == 2) set_write(AW'(1), 32'h55);
      if (i == 4) set_inval(AW'(7));
      cycle();
    end
    check_drain("back_to_back");
  endtask

  task automatic test_flush();
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      set_write(AW'(i), 32'hF000_0000 | i);
      cycle();
    end
    // Last IDLE search completes against its pre-flush snapshot.
    set_search(32'hF000_0005);
    cycle();
    flush_i = 1'b1;
    search_enable_i = 1'b1;
    search_data_i   = 32'hF000_0006;
    @(posedge clk);
    #1;
    n = 0;
    while (ready_o === 1'b0 && n < DEPTH + 4) begin
      n++;
      flush_i         = 1'b1;
      search_enable_i = 1'b1;
      search_data_i   = 32'hF000_0000 | n;
      write_enable_i  = 1'b1;
      write_index_i   = AW'(0);
      write_data_i    = 32'hF000_0007;
      read_enable_i   = 1'b1;
      read_index_i    = AW'(n);
      @(posedge clk);
      #1;
    end
    clear_inputs();
    model_clear_valid();
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL flush_busy_cycles: got %0d, expected %0d", n, DEPTH);
    end
    for (int i = 0; i < 4; i++) begin
      set_search(32'hF000_0000 | (i * 7));
      set_read(AW'(i * 9));
      cycle();
    end
    set_search(32'hF000_0007);
    cycle();
    check_drain("flush");
  endtask

  task automatic test_reset_mid_search();
    set_write(AW'(10), 32'h0BADCAFE);
    cycle();
    search_enable_i = 1'b1;
    search_data_i   = 32'h0BADCAFE;
    @(posedge clk);
    #1;
    clear_inputs();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_clear_valid();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (search_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_search_strobe: got %0d at cycle %0d, expected 0",
                 search_valid_o, i);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_flush();
    set_write(AW'(6), 32'hCAFEF00D);
    cycle();
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    clear_inputs();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_flush_busy: got ready=%0d, expected 0", ready_o);
    end
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_clear_valid();
    check_idle_outputs("reset_mid_flush");
    set_search(32'hCAFEF00D);
    cycle();
    set_read(AW'(6));
    cycle();
    check_drain("reset_mid_flush");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i]  = '0;
      m_valid[i] = 1'b0;
    end
    clear_inputs();
    rst_i = 1'b1;
    test_reset();
    test_basic_search();
    test_lowest_index();
    test_write_search_same();
    test_write_inval_same();
    test_back_to_back();
    test_flush();
    test_reset_mid_search();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
